// File: rtl/dmem_arbiter_pkg.sv
// Shared constants, funct3 codes and FSM encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

    localparam int MEM_SIZE         = 1024;
    localparam int INSTRUCTION_SIZE = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ISSUE = 2'd1,
        DMA_RESP  = 2'd2
    } dma_state_e;

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check of one access: size code vs direction
// and natural alignment of the byte address.
module dmem_access_check
    import dmem_arbiter_pkg::*;
(
    input  logic       we,
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       err
);

    logic size_ok;
    logic align_ok;

    always_comb begin
        size_ok  = 1'b0;
        align_ok = 1'b0;
        case (funct3)
            F3_B: begin
                size_ok  = 1'b1;
                align_ok = 1'b1;
            end
            F3_H: begin
                size_ok  = 1'b1;
                align_ok = !addr_lo[0];
            end
            F3_W: begin
                size_ok  = 1'b1;
                align_ok = (addr_lo == 2'b00);
            end
            // unsigned variants only exist for loads
            F3_BU: begin
                size_ok  = !we;
                align_ok = 1'b1;
            end
            F3_HU: begin
                size_ok  = !we;
                align_ok = !addr_lo[0];
            end
            default: begin
                size_ok  = 1'b0;
                align_ok = 1'b0;
            end
        endcase
        err = !(size_ok && align_ok);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data memory: core (port 0) and
// debug/DMA loader (port 1), one access per IDLE->ISSUE->RESP round trip.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = $clog2(MEM_SIZE),
    parameter int DATA_W = INSTRUCTION_SIZE,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic [2:0]        p0_req_funct3,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    output logic              p0_rsp_err,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [2:0]        p1_req_funct3,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              p1_rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [2:0]        mem_funct3,
    input  logic [DATA_W-1:0] mem_read_data
);

    dma_state_e        state_q, state_d;
    logic              rr_last_q, rr_last_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              gnt0, gnt1;
    logic              idle, accept;
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [2:0]        s_f3;
    logic              s_err;
    logic              rsp_ack;
    logic              rsp0, rsp1;

    // rr_last names the port granted most recently; the other one wins a tie
    always_comb begin
        gnt1 = p1_req_valid &&
               (!p0_req_valid || ((RR_EN != 0) && !rr_last_q));
        gnt0 = p0_req_valid && !gnt1;
    end

    assign idle         = (state_q == DMA_IDLE);
    assign p0_req_ready = idle && gnt0;
    assign p1_req_ready = idle && gnt1;
    assign accept       = p0_req_ready || p1_req_ready;

    assign s_we    = gnt1 ? p1_req_we     : p0_req_we;
    assign s_addr  = gnt1 ? p1_req_addr   : p0_req_addr;
    assign s_wdata = gnt1 ? p1_req_wdata  : p0_req_wdata;
    assign s_f3    = gnt1 ? p1_req_funct3 : p0_req_funct3;

    dmem_access_check u_check (
        .we      (s_we),
        .funct3  (s_f3),
        .addr_lo (s_addr[1:0]),
        .err     (s_err)
    );

    assign rsp_ack = port_q ? p1_rsp_ready : p0_rsp_ready;

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        unique case (state_q)
            DMA_IDLE: begin
                if (accept) begin
                    rr_last_d = gnt1;
                    port_d    = gnt1;
                    err_d     = s_err;
                    rdata_d   = '0;
                    // rejected requests leave the memory-side regs untouched
                    if (s_err) begin
                        state_d = DMA_RESP;
                    end else begin
                        state_d = DMA_ISSUE;
                        we_d    = s_we;
                        addr_d  = s_addr;
                        wdata_d = s_wdata;
                        f3_d    = s_f3;
                    end
                end
            end
            DMA_ISSUE: begin
                rdata_d = we_q ? '0 : mem_read_data;
                state_d = DMA_RESP;
            end
            DMA_RESP: begin
                if (rsp_ack) begin
                    state_d = DMA_IDLE;
                end
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= DMA_IDLE;
            rr_last_q <= 1'b1;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f3_q      <= 3'b000;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            port_q    <= port_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            f3_q      <= f3_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign mem_read       = (state_q == DMA_ISSUE) && !we_q;
    assign mem_write      = (state_q == DMA_ISSUE) && we_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_funct3     = f3_q;

    assign rsp0 = (state_q == DMA_RESP) && !port_q;
    assign rsp1 = (state_q == DMA_RESP) && port_q;

    assign p0_rsp_valid = rsp0;
    assign p1_rsp_valid = rsp1;
    assign p0_rsp_rdata = rsp0 ? rdata_q : '0;
    assign p1_rsp_rdata = rsp1 ? rdata_q : '0;
    assign p0_rsp_err   = rsp0 && err_q;
    assign p1_rsp_err   = rsp1 && err_q;

endmodule
